// File: rtl/huffman_block_sequencer_pkg.sv
// Shared JPEG entropy-stage definitions: coefficient width, scan constants and
// the block sequencer state encoding.
package huffman_block_sequencer_pkg;

    localparam int COEF_W   = 8;
    localparam int NUM_COEF = 64;
    localparam int IDX_W    = 6;
    localparam int RUN_W    = 4;

    localparam logic [RUN_W-1:0] ZRL_RUN  = 4'd15;
    localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DC,
        S_SCAN,
        S_ZRL,
        S_EOB,
        S_DONE
    } state_t;

endpackage

// File: rtl/huffman_block_sequencer_nz_above.sv
// Reports whether any coefficient strictly above idx is nonzero, given the
// per-coefficient nonzero mask of the current block.
module nz_above_detect
    import huffman_block_sequencer_pkg::*;
(
    input  logic [NUM_COEF-1:0] nz_mask,
    input  logic [IDX_W-1:0]    idx,
    output logic                any_above
);

    logic [NUM_COEF-1:0] shifted;

    assign shifted   = nz_mask >> idx;
    assign any_above = |(shifted >> 1);

endmodule

// File: rtl/huffman_block_sequencer.sv
// Walks one zigzag-ordered block and emits the DC difference followed by
// run/value AC symbols, ZRL and EOB markers for the Huffman encoder.
module huffman_block_sequencer #(
    parameter int COEF_W = huffman_block_sequencer_pkg::COEF_W
) (
    input  logic                                                 clock,
    input  logic                                                 reset_n,
    input  logic [huffman_block_sequencer_pkg::NUM_COEF*COEF_W-1:0] zigzag_pix_in,
    input  logic                                                 blk_valid,
    output logic                                                 blk_ready,
    input  logic                                                 dc_pred_clr,
    output logic                                                 sym_valid,
    input  logic                                                 sym_ready,
    output logic                                                 sym_is_dc,
    output logic [3:0]                                           sym_run,
    output logic [COEF_W:0]                                      sym_value,
    output logic                                                 sym_eob,
    output logic                                                 sym_zrl,
    output logic                                                 blk_done,
    output huffman_block_sequencer_pkg::state_t                  state_dbg
);
    import huffman_block_sequencer_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never depends on ready, and offered data holds until taken.

    state_t                     state, state_nxt;
    logic [NUM_COEF*COEF_W-1:0] blk_q;
    logic [NUM_COEF-1:0]        nz_mask_q, nz_in;
    logic [IDX_W-1:0]           k_q;
    logic [RUN_W-1:0]           run_q;
    logic [COEF_W-1:0]          dc_pred_q;
    logic                       clr_pend_q;
    logic                       nz_above;
    logic [COEF_W-1:0]          coef0, coef_k;
    logic [COEF_W:0]            dc_diff;

    always_comb begin
        nz_in = '0;
        for (int i = 0; i < NUM_COEF; i++) nz_in[i] = |zigzag_pix_in[i*COEF_W +: COEF_W];
    end

    nz_above_detect u_nz_above (
        .nz_mask   (nz_mask_q),
        .idx       (k_q),
        .any_above (nz_above)
    );

    assign coef0     = blk_q[COEF_W-1:0];
    assign coef_k    = blk_q[int'(k_q)*COEF_W +: COEF_W];
    assign dc_diff   = {coef0[COEF_W-1], coef0} - {dc_pred_q[COEF_W-1], dc_pred_q};
    assign state_dbg = state;

    // After DC or an AC symbol, jump straight to EOB when nothing nonzero remains.
    always_comb begin
        state_nxt = state;
        blk_ready = 1'b0;
        blk_done  = 1'b0;
        sym_valid = 1'b0;
        sym_is_dc = 1'b0;
        sym_eob   = 1'b0;
        sym_zrl   = 1'b0;
        sym_run   = '0;
        sym_value = '0;
        case (state)
            S_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) state_nxt = S_DC;
            end
            S_DC: begin
                sym_valid = 1'b1;
                sym_is_dc = 1'b1;
                sym_value = dc_diff;
                if (sym_ready) state_nxt = nz_above ? S_SCAN : S_EOB;
            end
            S_SCAN: begin
                if (nz_mask_q[k_q]) begin
                    sym_valid = 1'b1;
                    sym_run   = run_q;
                    sym_value = {coef_k[COEF_W-1], coef_k};
                    if (sym_ready) begin
                        if (k_q == LAST_IDX) state_nxt = S_DONE;
                        else                 state_nxt = nz_above ? S_SCAN : S_EOB;
                    end
                end else if (!nz_above) begin
                    state_nxt = S_EOB;
                end else if (run_q == ZRL_RUN) begin
                    state_nxt = S_ZRL;
                end
            end
            S_ZRL: begin
                sym_valid = 1'b1;
                sym_zrl   = 1'b1;
                sym_run   = ZRL_RUN;
                if (sym_ready) state_nxt = S_SCAN;
            end
            S_EOB: begin
                sym_valid = 1'b1;
                sym_eob   = 1'b1;
                if (sym_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                blk_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            blk_q      <= '0;
            nz_mask_q  <= '0;
            k_q        <= '0;
            run_q      <= '0;
            dc_pred_q  <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (dc_pred_clr) dc_pred_q <= '0;
                    if (blk_valid) begin
                        blk_q     <= zigzag_pix_in;
                        nz_mask_q <= nz_in;
                        k_q       <= '0;
                        run_q     <= '0;
                    end
                end
                S_DC: begin
                    if (sym_ready) begin
                        dc_pred_q <= coef0;
                        k_q       <= 6'd1;
                        run_q     <= '0;
                    end
                end
                S_SCAN: begin
                    if (nz_mask_q[k_q]) begin
                        if (sym_ready) begin
                            run_q <= '0;
                            k_q   <= k_q + 6'd1;
                        end
                    end else if (nz_above && run_q != ZRL_RUN) begin
                        run_q <= run_q + 4'd1;
                        k_q   <= k_q + 6'd1;
                    end
                end
                S_ZRL: begin
                    if (sym_ready) begin
                        run_q <= '0;
                        k_q   <= k_q + 6'd1;
                    end
                end
                S_DONE: begin
                    if (clr_pend_q || dc_pred_clr) dc_pred_q <= '0;
                end
                default: ;
            endcase
            // A clear seen mid-block is held until the block completes.
            if (state == S_DONE)                      clr_pend_q <= 1'b0;
            else if (state != S_IDLE && dc_pred_clr)  clr_pend_q <= 1'b1;
        end
    end

endmodule

// File: doc/huffman_block_sequencer.md
HUFFMAN_BLOCK_SEQUENCER -- requirements
Module: huffman_block_sequencer

Interface
REQ-001 Parameter COEF_W, default 8, signed two's-complement width of one quantized zigzag coefficient.
REQ-002 Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- zigzag_pix_in  in  512  64 coefficients; coefficient k at bits [8k+7:8k], k=0 is DC.
- blk_valid  in  1  block present on zigzag_pix_in.
- blk_ready  out  1  sequencer can accept a block.
- dc_pred_clr  in  1  clear the DC predictor (start of scan or restart interval).
- sym_valid  out  1  symbol offered to the Huffman encoder.
- sym_ready  in  1  encoder accepts the symbol.
- sym_is_dc  out  1  symbol is the DC difference.
- sym_run  out  4  preceding zero-run length (AC only; 0 for DC/EOB; 15 for ZRL).
- sym_value  out  9  signed value: DC difference or AC coefficient, sign-extended; 0 for EOB/ZRL.
- sym_eob  out  1  end-of-block symbol.
- sym_zrl  out  1  sixteen-zero run symbol.
- blk_done  out  1  one-cycle pulse after the last symbol of a block is accepted.

Function
REQ-003 The FSM states SHALL be IDLE, DC, SCAN, ZRL, EOB, DONE.
REQ-004 blk_ready SHALL be 1 only in IDLE; a block is accepted when blk_valid and blk_ready are both 1, and is latched into an internal 512-bit register with a 64-bit nonzero mask.
REQ-005 On acceptance the FSM SHALL go to DC; sym_valid SHALL be 1 in the cycle after acceptance.
REQ-006 In DC, sym_is_dc=1, sym_value = coef[0] - dc_pred, computed at 9 bits, sym_run=0; on the handshake dc_pred <= coef[0], index k <= 1, run <= 0, next SCAN.
REQ-007 In SCAN, with k in 1..63: if coef[k] and all higher coefficients are zero, go to EOB without consuming a cycle of sym_valid for coef[k].
REQ-008 In SCAN, if coef[k]==0 and a nonzero exists above k: if run<15 then run++ and k++ with sym_valid=0 (one zero per cycle); if run==15 then go to ZRL.
REQ-009 In SCAN, if coef[k]!=0: sym_valid=1, sym_run=run, sym_value=sign-extended coef[k]; on the handshake run<=0, k++; if k was 63, go to DONE, otherwise stay in SCAN.
REQ-010 In ZRL, sym_zrl=1, sym_run=15, sym_value=0; on the handshake run<=0, k++, return to SCAN.
REQ-011 In EOB, sym_eob=1, sym_run=0, sym_value=0; on the handshake go to DONE.
REQ-012 EOB SHALL NOT be emitted when coef[63] is nonzero; ZRL SHALL NOT be emitted unless a nonzero coefficient follows.
REQ-013 DONE SHALL assert blk_done for one cycle and return to IDLE; a new block can be accepted the next cycle.
REQ-014 While sym_valid=1 and sym_ready=0, all sym_* outputs SHALL remain stable and the FSM SHALL not advance.
REQ-015 dc_pred_clr SHALL set dc_pred to 0 when sampled in IDLE; in other states it SHALL take effect after the current block reaches DONE.
REQ-016 At most one of sym_is_dc, sym_eob, sym_zrl SHALL be 1 at any time, and each SHALL be 0 whenever sym_valid=0.

Reset
REQ-017 When reset_n=0 at a rising edge, the FSM SHALL go to IDLE; k=0, run=0, dc_pred=0; the pending dc_pred_clr SHALL be cleared; sym_valid=0, all sym_* outputs =0, blk_done=0, blk_ready=1 on the first cycle after reset.
REQ-018 A reset asserted mid-block SHALL discard the block with no further symbols and no blk_done pulse.

Structure
REQ-019 The FSM state encoding, COEF_W, and the constants ZRL_RUN=15 and LAST_IDX=63 SHALL live in the shared JPEG package.
REQ-020 The "any nonzero above k" test SHALL be a sub-module named nz_above_detect (64-bit mask, 6-bit index -> 1 bit).

Verification
REQ-021 All-zero block, dc_pred=0, sym_ready=1 -> DC(value 0), then EOB; blk_done pulses 3 cycles after acceptance.
REQ-022 Block with coef0=10 followed by coef0=4 (no clear) -> DC values 10 then -6; with dc_pred_clr in between -> 10 then 4.
REQ-023 Only coef[20]=-3 nonzero -> DC, ZRL, AC(run=3, value=-3), EOB.
REQ-024 Only coef[63]=1 -> DC, ZRL, ZRL, ZRL, AC(run=14, value=1), no EOB, blk_done.
REQ-025 Random sym_ready backpressure on a dense block -> sym_* stable while stalled, 64 symbols in order with run 0.
REQ-026 reset_n=0 during SCAN -> sym_valid=0 next cycle, no blk_done, blk_ready=1, dc_pred=0.
